eth_tx_framer: RTL and testbench
================================

ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
- REQ-001: Parameter IFG_LEN, default 12, idle cycles (valid low) enforced after every frame, including aborted ones.
- REQ-002: Parameter MIN_FRAME_LEN, default 60, minimum bytes from dest MAC to end of pad, excluding FCS.
- REQ-003: clk  input  1  single clock; all logic on posedge.
- REQ-004: rst  input  1  synchronous, active-high reset.
- REQ-005: s_data  input  8  frame byte (dest MAC, src MAC, ethertype, payload, in wire order).
- REQ-006: s_valid  input  1  s_data valid.
- REQ-007: s_last  input  1  s_data is the final frame byte.
- REQ-008: s_ready  output  1  framer accepts s_data this cycle.
- REQ-009: gmii_if_tx_o  gmii_if.master  -  registered GMII transmit: data[7:0], valid.
- REQ-010: tx_busy_o  output  1  high in every state except IDLE.
- REQ-011: tx_done_o  output  1  one-cycle pulse in the cycle after the final frame byte leaves gmii_if_tx_o.
- REQ-012: tx_underrun_o  output  1  one-cycle pulse on mid-frame underrun.

Function
- REQ-013: States are IDLE, PREAMBLE, SFD, DATA, PAD, FCS and IFG.
- REQ-014: IDLE with s_valid=1 goes to PREAMBLE. gmii_if_tx_o.valid=1 from the next cycle. s_data is not consumed in IDLE.
- REQ-015: PREAMBLE drives 0x55 for exactly 7 cycles, then goes to SFD.
- REQ-016: SFD drives 0xD5 for 1 cycle, then goes to DATA.
- REQ-017: s_ready is 1 only in SFD and DATA. It is 0 in the cycle after a handshake with s_last=1.
- REQ-018: A byte accepted (s_valid&s_ready) on edge n appears on gmii_if_tx_o at cycle n+1. Output is back-to-back with no gaps.
- REQ-019: A 16-bit saturating counter counts frame bytes from dest MAC onward. It clears in IDLE.
- REQ-020: On s_last, if count < MIN_FRAME_LEN, go to PAD. Otherwise go to FCS.
- REQ-021: PAD drives 0x00 until count = MIN_FRAME_LEN, then goes to FCS.
- REQ-022: FCS is Ethernet CRC-32: reflected polynomial 0x04C11DB7, init 0xFFFFFFFF, final complement.
- REQ-023: The CRC covers dest MAC through the last pad byte.
- REQ-024: The FCS is sent as 4 bytes, least-significant byte first.
- REQ-025: After the final FCS byte, go to IFG and pulse tx_done_o.
- REQ-026: IFG holds valid=0 and data=0x00 for IFG_LEN cycles, then goes to IDLE.
- REQ-027: Underrun: in SFD or DATA, s_valid=0 before s_last aborts the frame. Response: valid=0 next cycle, tx_underrun_o pulse, no pad, no FCS, no tx_done_o, then IFG.
- REQ-028: In SFD, s_ready=1 and s_valid=0 is not an underrun. The first data byte may arrive until DATA begins.
- REQ-029: s_valid during PREAMBLE, PAD, FCS or IFG is ignored, and s_ready=0 in those states.
- REQ-030: A new frame may start on the cycle IFG exits to IDLE, with no extra idle cycle.
- REQ-031: A single-byte frame (s_last on the first byte) is legal. It is padded to MIN_FRAME_LEN.

Reset
- REQ-032: On rst, the state goes to IDLE and all counters clear.
- REQ-033: Reset values: gmii_if_tx_o.valid=0, gmii_if_tx_o.data=0x00, s_ready=0, tx_busy_o=0, tx_done_o=0, tx_underrun_o=0.
- REQ-034: Reset mid-frame truncates the frame immediately. No FCS, no IFG and no pulses follow.

Configuration
- REQ-035: Macro ETH_TX_FCS_EN.
- REQ-036: With ETH_TX_FCS_EN defined, PAD and FCS behave as specified above.
- REQ-037: Without ETH_TX_FCS_EN, the PAD and FCS states and the CRC logic are not synthesised.
- REQ-038: Without ETH_TX_FCS_EN, s_last goes straight to IFG, with tx_done_o pulsing after the last s_data byte. Upstream then supplies pad and FCS.

Verification
- REQ-039: 64-byte frame, s_valid held high -> 7x0x55, 0xD5, 64 input bytes, 4 FCS bytes, all with valid continuous. FCS equals the reference model. CRC over dest MAC..FCS yields residue 0xC704DD7B. 12 idle cycles follow.
- REQ-040: 14-byte frame (header only) -> 46 bytes of 0x00 pad, then FCS over 60 bytes, with tx_done_o once.
- REQ-041: 30-byte frame with s_valid dropped after byte 20 -> valid=0 next cycle, tx_underrun_o pulse, no FCS, and the next frame no earlier than 12 cycles later.
- REQ-042: Back-to-back frames with s_valid asserted throughout IFG -> exactly IFG_LEN idle cycles between the last FCS byte and the next 0x55.
- REQ-043: rst asserted during DATA -> valid=0 and outputs at reset values on the next cycle. A following frame is transmitted correctly.
- REQ-044: ETH_TX_FCS_EN undefined, 20-byte frame -> preamble, SFD, 20 bytes, then IFG, with no pad and no FCS.

Source files
------------

// File: rtl/gmii_if.sv
// gmii_if: GMII transmit byte stream (data plus valid) between framer and PHY.
interface gmii_if;
  logic [7:0] data;
  logic       valid;
  modport master (output data, valid);
  modport slave  (input data, valid);
endinterface

// File: rtl/eth_tx_framer.sv
// eth_tx_framer: Ethernet TX framer (preamble/SFD, data, IFG; pad and CRC-32 FCS when ETH_TX_FCS_EN is defined).
module eth_tx_framer #(
  parameter int IFG_LEN       = 12,
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  gmii_if.master     gmii_if_tx_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_underrun_o
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, IFG
`ifdef ETH_TX_FCS_EN
    , PAD, FCS
`endif
  } state_t;
  localparam logic [15:0] IFG_T = 16'(IFG_LEN);
  state_t      st, end_st;
  logic [15:0] bcnt, bnext, tcnt;
  logic        last_out;
  assign s_ready   = st == SFD || st == DATA;
  assign tx_busy_o = st != IDLE;
  assign bnext     = &bcnt ? bcnt : bcnt + 16'd1;
`ifdef ETH_TX_FCS_EN
  localparam logic [15:0] MIN_T = 16'(MIN_FRAME_LEN);
  logic [31:0] crc, fcs;
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  assign fcs    = ~crc;
  assign end_st = bnext < MIN_T ? PAD : FCS;
`else
  assign end_st = IFG;
`endif
  // Output bytes are registered one edge after the state that produces them,
  // so the IFG timer of a completed frame includes the cycle its last byte is on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      st                 <= IDLE;
      bcnt               <= '0;
      tcnt               <= '0;
      last_out           <= 1'b0;
      gmii_if_tx_o.data  <= 8'h00;
      gmii_if_tx_o.valid <= 1'b0;
      tx_done_o          <= 1'b0;
      tx_underrun_o      <= 1'b0;
`ifdef ETH_TX_FCS_EN
      crc                <= '1;
`endif
    end else begin
      tx_done_o     <= last_out;
      last_out      <= 1'b0;
      tx_underrun_o <= 1'b0;
      case (st)
        IDLE, IFG: begin
          if (st == IFG && tcnt != 16'd0) begin
            tcnt               <= tcnt - 16'd1;
            gmii_if_tx_o.data  <= 8'h00;
            gmii_if_tx_o.valid <= 1'b0;
          end else begin
            st                 <= s_valid ? PREAMBLE : IDLE;
            gmii_if_tx_o.data  <= s_valid ? 8'h55 : 8'h00;
            gmii_if_tx_o.valid <= s_valid;
            bcnt               <= '0;
            tcnt               <= '0;
`ifdef ETH_TX_FCS_EN
            crc                <= '1;
`endif
          end
        end
        PREAMBLE: begin
          st                <= tcnt == 16'd6 ? SFD : PREAMBLE;
          tcnt              <= tcnt == 16'd6 ? 16'd0 : tcnt + 16'd1;
          gmii_if_tx_o.data <= tcnt == 16'd6 ? 8'hD5 : 8'h55;
        end
        SFD, DATA: begin
          if (s_valid) begin
            gmii_if_tx_o.data  <= s_data;
            gmii_if_tx_o.valid <= 1'b1;
            bcnt               <= bnext;
            st                 <= s_last ? end_st : DATA;
            tcnt               <= s_last && end_st == IFG ? IFG_T : 16'd0;
            last_out           <= s_last && end_st == IFG;
`ifdef ETH_TX_FCS_EN
            crc                <= crc8(crc, s_data);
`endif
          end else begin
            gmii_if_tx_o.data  <= 8'h00;
            gmii_if_tx_o.valid <= 1'b0;
            st                 <= st == DATA ? IFG : DATA;
            tcnt               <= st == DATA ? IFG_T - 16'd1 : 16'd0;
            tx_underrun_o      <= st == DATA;
          end
        end
`ifdef ETH_TX_FCS_EN
        PAD: begin
          gmii_if_tx_o.data <= 8'h00;
          bcnt              <= bnext;
          crc               <= crc8(crc, 8'h00);
          st                <= bnext >= MIN_T ? FCS : PAD;
        end
        FCS: begin
          gmii_if_tx_o.data <= fcs[{tcnt[1:0], 3'b000} +: 8];
          st                <= tcnt == 16'd3 ? IFG : FCS;
          tcnt              <= tcnt == 16'd3 ? IFG_T : tcnt + 16'd1;
          last_out          <= tcnt == 16'd3;
        end
`endif
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed/random frame bench for eth_tx_framer with a byte-stream reference model.
module tb_eth_tx_framer;
  localparam int IFG_LEN = 12;
  localparam int MIN_LEN = 60;
  logic clk = 0, rst = 1, s_valid = 0, s_last = 0;
  logic [7:0] s_data = 0;
  logic s_ready, tx_busy_o, tx_done_o, tx_underrun_o;
  int nvec = 0, nerr = 0, last_gap = -1;
  int idle_cnt = 0, ndone = 0, nund = 0;
  logic prev_v = 0;
  logic [7:0] frm[$], exp_q[$], cap[$];
  int gaps[$];

  gmii_if gmii ();
  eth_tx_framer #(.IFG_LEN(IFG_LEN), .MIN_FRAME_LEN(MIN_LEN)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .gmii_if_tx_o(gmii), .tx_busy_o(tx_busy_o),
    .tx_done_o(tx_done_o), .tx_underrun_o(tx_underrun_o));

  always #5 clk = ~clk;

  // Wire monitor: captured bytes, idle run length before each burst, pulse counts.
  always @(negedge clk) begin
    if (gmii.valid === 1'b1) begin
      if (!prev_v) gaps.push_back(idle_cnt);
      cap.push_back(gmii.data);
      idle_cnt <= 0;
    end else idle_cnt <= idle_cnt + 1;
    prev_v <= gmii.valid === 1'b1;
    if (tx_done_o === 1'b1) ndone <= ndone + 1;
    if (tx_underrun_o === 1'b1) nund <= nund + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

`ifdef ETH_TX_FCS_EN
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction
`endif

  // Expected wire image: preamble, SFD, sent bytes, then pad and FCS for completed frames.
  task automatic build(input int n_sent, input bit full);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < n_sent; i++) exp_q.push_back(frm[i]);
`ifdef ETH_TX_FCS_EN
    if (full) begin
      logic [31:0] r;
      while (exp_q.size() - 8 < MIN_LEN) exp_q.push_back(8'h00);
      r = 32'hFFFFFFFF;
      for (int i = 8; i < exp_q.size(); i++) r = crc_upd(r, exp_q[i]);
      r = ~r;
      for (int i = 0; i < 4; i++) exp_q.push_back(8'(r >> (8 * i)));
    end
`else
    if (full) exp_q.push_back(8'h00);
    if (full) void'(exp_q.pop_back());
`endif
  endtask

  task automatic send(input int n, input int drop, input bit hold, input bit rst_mode);
    int i, t;
    bit hs;
    i = 0;
    t = 0;
    s_valid = 1;
    s_data = frm[0];
    s_last = (n == 1);
    while (i < n && t < 400) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      t++;
      if (hs) begin
        i++;
        if (i == drop) begin
          if (rst_mode) rst = 1;
          s_valid = 0;
          break;
        end
        if (i < n) begin
          s_data = frm[i];
          s_last = (i == n - 1);
        end
      end
    end
    chk("bytes_accepted", i, drop < 0 ? n : drop);
    if (!hold) s_valid = 0;
    s_last = 0;
  endtask

  task automatic wait_end(input int d0, input int u0);
    int t;
    t = 0;
    while (ndone == d0 && nund == u0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("end_within_bound", t < 300, 1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (tx_busy_o !== 1'b0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("idle_within_bound", tx_busy_o, 0);
  endtask

  task automatic do_frame(input string tag, input int n, input int drop, input bit hold);
    int c0, g0, d0, u0;
    c0 = cap.size();
    g0 = gaps.size();
    d0 = ndone;
    u0 = nund;
    frm.delete();
    for (int i = 0; i < n; i++) frm.push_back(8'($urandom));
    send(n, drop, hold, 0);
    wait_end(d0, u0);
    build(drop < 0 ? n : drop, drop < 0);
    chk($sformatf("%s_len", tag), cap.size() - c0, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (c0 + i < cap.size()) chk($sformatf("%s_byte%0d", tag, i), cap[c0 + i], exp_q[i]);
    chk($sformatf("%s_done", tag), ndone - d0, drop < 0 ? 1 : 0);
    chk($sformatf("%s_underrun", tag), nund - u0, drop < 0 ? 0 : 1);
    chk($sformatf("%s_bursts", tag), gaps.size() - g0, 1);
    if (gaps.size() > g0) last_gap = gaps[g0];
`ifdef ETH_TX_FCS_EN
    if (drop < 0 && cap.size() > c0 + 8) begin
      logic [31:0] r, rv;
      r = 32'hFFFFFFFF;
      for (int i = c0 + 8; i < cap.size(); i++) r = crc_upd(r, cap[i]);
      rv = {<<{r}};
      chk($sformatf("%s_residue", tag), rv, 32'hC704DD7B);
    end
`endif
  endtask

  initial begin
    int d0, u0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", gmii.valid, 0);
    chk("rst_data", gmii.data, 0);
    chk("rst_ready", s_ready, 0);
    chk("rst_busy", tx_busy_o, 0);
    chk("rst_done", tx_done_o, 0);
    chk("rst_underrun", tx_underrun_o, 0);
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    do_frame("f64a", 64, -1, 1);
    do_frame("f64b", 64, -1, 0);
    chk("b2b_gap", last_gap, IFG_LEN);
    wait_idle();
    do_frame("f14", 14, -1, 0);
    wait_idle();
    do_frame("f1", 1, -1, 0);
    wait_idle();
    do_frame("under", 30, 20, 0);
    do_frame("after_under", 20, -1, 0);
    chk("under_gap_min", last_gap >= IFG_LEN, 1);
    wait_idle();
    frm.delete();
    for (int i = 0; i < 40; i++) frm.push_back(8'($urandom));
    d0 = ndone;
    u0 = nund;
    send(40, 10, 0, 1);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", gmii.valid, 0);
    chk("mid_rst_data", gmii.data, 0);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", tx_busy_o, 0);
    chk("mid_rst_done", tx_done_o, 0);
    chk("mid_rst_underrun", tx_underrun_o, 0);
    rst = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_rst_no_done", ndone - d0, 0);
    chk("mid_rst_no_underrun", nund - u0, 0);
    do_frame("post_rst", 25, -1, 0);
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      int n;
      bit h;
      n = int'($urandom_range(1, 100));
      h = (k < 3) && ($urandom_range(0, 1) == 1);
      do_frame($sformatf("rnd%0d", k), n, -1, h);
    end
    s_valid = 0;
    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
